// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port arbiter and fixed wait-state controller for the 32-bit off-chip SRAM
// Ports: clk/rst (async active-high); p0_*/p1_* request ports (rd_en, wr_en, addr, wdata -> rdata, ready);
//   SRAM_WE_N/SRAM_ADDR/SRAM_DQ SRAM pins; busy (state != IDLE); grant_id (owner of current/last access).
// Build option: define SRAM_ARB_RR_EN for round-robin arbitration; fixed priority (port 0) otherwise.
module sram_arbiter #(
  parameter int WAIT_CYCLES = 5,
  parameter int ADDR_BASE   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_rd_en,
  input  logic        p0_wr_en,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic [31:0] p0_rdata,
  output logic        p0_ready,
  input  logic        p1_rd_en,
  input  logic        p1_wr_en,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic [31:0] p1_rdata,
  output logic        p1_ready,
  output logic        SRAM_WE_N,
  output logic [16:0] SRAM_ADDR,
  inout  wire  [31:0] SRAM_DQ,
  output logic        busy,
  output logic        grant_id
);
  localparam int CW = $clog2(WAIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic we_n_q, we_n_d, oe_q, oe_d, wr_q, wr_d, busy_q, busy_d, grant_q, grant_d;
  logic [16:0] sram_addr_q, sram_addr_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic req0, req1, gnt;
  logic [31:0] sel_addr;
  assign req0 = p0_rd_en | p0_wr_en;
  assign req1 = p1_rd_en | p1_wr_en;
`ifdef SRAM_ARB_RR_EN
  logic last_q, last_d;
  assign gnt = (req0 & req1) ? ~last_q : ~req0;
`else
  assign gnt = ~req0;
`endif
  assign sel_addr = gnt ? p1_addr : p0_addr;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    we_n_d = we_n_q;
    oe_d = oe_q;
    wr_d = wr_q;
    grant_d = grant_q;
    sram_addr_d = sram_addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef SRAM_ARB_RR_EN
    last_d = last_q;
`endif
    if (state_q == IDLE && (req0 | req1)) begin
      state_d = ACCESS;
      cnt_d = '0;
      grant_d = gnt;
      // both enables set counts as a write
      wr_d = gnt ? p1_wr_en : p0_wr_en;
      // below-base addresses wrap modulo the 2^17-word window
      sram_addr_d = 17'((sel_addr - 32'(ADDR_BASE)) >> 2);
      wdata_d = gnt ? p1_wdata : p0_wdata;
      we_n_d = ~wr_d;
      oe_d = wr_d;
`ifdef SRAM_ARB_RR_EN
      last_d = gnt;
`endif
    end else if (state_q == ACCESS && cnt_q == LAST) begin
      state_d = DONE;
      we_n_d = 1'b1;
      oe_d = 1'b0;
      rdata_d = wr_q ? rdata_q : SRAM_DQ;
    end else if (state_q == ACCESS) begin
      cnt_d = cnt_q + 1'b1;
      // release WE_N one cycle early so data is held past the write strobe
      we_n_d = ~(wr_q && cnt_d != LAST);
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      we_n_q <= 1'b1;
      oe_q <= 1'b0;
      wr_q <= 1'b0;
      busy_q <= 1'b0;
      grant_q <= 1'b0;
      sram_addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef SRAM_ARB_RR_EN
      last_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      we_n_q <= we_n_d;
      oe_q <= oe_d;
      wr_q <= wr_d;
      busy_q <= busy_d;
      grant_q <= grant_d;
      sram_addr_q <= sram_addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef SRAM_ARB_RR_EN
      last_q <= last_d;
`endif
    end
  end
  assign SRAM_WE_N = we_n_q;
  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_DQ = oe_q ? wdata_q : 32'bz;
  assign busy = busy_q;
  assign grant_id = grant_q;
  assign p0_rdata = rdata_q;
  assign p1_rdata = rdata_q;
  assign p0_ready = ~req0 | (state_q == DONE && !grant_q);
  assign p1_ready = ~req1 | (state_q == DONE && grant_q);
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: randomized transaction-level check of sram_arbiter against a memory/arbitration model
module tb_sram_arbiter;
  localparam int W = 5;
  localparam int BASE = 1024;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] rd = '0, wr = '0;
  logic [31:0] ad [2];
  logic [31:0] wd [2];
  logic [31:0] p0_rdata, p1_rdata;
  logic p0_ready, p1_ready, SRAM_WE_N, busy, grant_id;
  logic [16:0] SRAM_ADDR;
  wire [31:0] SRAM_DQ;
  logic [31:0] sram [0:131071];
  logic wacc = 1'b0, probe = 1'b0;
  logic [31:0] ref_mem [int];
  bit last_g = 1'b1;
  int n_chk = 0, n_fail = 0;
  sram_arbiter #(.WAIT_CYCLES(W), .ADDR_BASE(BASE)) dut (
    .clk(clk), .rst(rst),
    .p0_rd_en(rd[0]), .p0_wr_en(wr[0]), .p0_addr(ad[0]), .p0_wdata(wd[0]),
    .p0_rdata(p0_rdata), .p0_ready(p0_ready),
    .p1_rd_en(rd[1]), .p1_wr_en(wr[1]), .p1_addr(ad[1]), .p1_wdata(wd[1]),
    .p1_rdata(p1_rdata), .p1_ready(p1_ready),
    .SRAM_WE_N(SRAM_WE_N), .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ),
    .busy(busy), .grant_id(grant_id)
  );
  always #5 clk = ~clk;
  // SRAM model: drives the bus only during non-write accesses, or when probing the bus
  assign SRAM_DQ = probe ? 32'h0 : ((busy & SRAM_WE_N & ~wacc) ? sram[SRAM_ADDR] : 32'bz);
  always @(negedge clk) wacc <= busy & (wacc | ~SRAM_WE_N);
  always @(posedge clk) if (!rst && !SRAM_WE_N) sram[SRAM_ADDR] <= SRAM_DQ;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic int widx(logic [31:0] a);
    logic [31:0] d = a - 32'(BASE);
    return int'((d / 4) % 131072);
  endfunction
  function automatic logic [31:0] pick();
    int k = $urandom_range(0, 4);
    return k == 3 ? 32'(BASE + 4 * 131071) : k == 4 ? 32'(BASE - 4) : 32'(BASE + 4 * $urandom_range(0, 7));
  endfunction
  // Entered at a negedge in IDLE with requests applied; leaves at the negedge of the following IDLE cycle
  task automatic round();
    bit r0 = rd[0] | wr[0];
    bit r1 = rd[1] | wr[1];
    bit w, isw;
    int wi, c = 0, wel = 0;
    logic [31:0] wdat, exp_rd;
`ifdef SRAM_ARB_RR_EN
    w = (r0 & r1) ? ~last_g : ~r0;
    last_g = w;
`else
    w = ~r0;
`endif
    isw = wr[w];
    wi = widx(ad[w]);
    wdat = wd[w];
    exp_rd = ref_mem.exists(wi) ? ref_mem[wi] : 32'h0;
    while (1) begin
      #1;
      if (c == 0) chk("busy_idle", busy, 0);
      if (c == 1) begin
        chk("sram_addr", SRAM_ADDR, 32'(wi));
        chk("grant_id", grant_id, w);
        chk("busy_access", busy, 1);
      end
      if (!SRAM_WE_N) wel++;
      if ((w ? r0 : r1) && c > 0) chk("loser_ready", w ? p0_ready : p1_ready, 0);
      if ((w ? p1_ready : p0_ready) || c == W + 3) break;
      c++;
      @(negedge clk);
    end
    chk("latency", 32'(c), 32'(W + 1));
    chk("we_low_cycles", 32'(wel), isw ? 32'(W - 1) : 32'h0);
    if (isw) ref_mem[wi] = wdat;
    else chk("rdata", w ? p1_rdata : p0_rdata, exp_rd);
    rd[w] = 1'b0;
    wr[w] = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    for (int i = 0; i < 131072; i++) sram[i] = 32'h0;
    ad[0] = '0; ad[1] = '0; wd[0] = '0; wd[1] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_we_n", SRAM_WE_N, 1);
    chk("rst_busy", busy, 0);
    chk("rst_p0_ready", p0_ready, 1);
    chk("rst_p1_ready", p1_ready, 1);
    chk("rst_grant", grant_id, 0);
    chk("rst_sram_addr", SRAM_ADDR, 0);
    probe = 1'b1;
    #1 chk("rst_dq_release", SRAM_DQ, 32'h0);
    probe = 1'b0;
    @(negedge clk);
    wr[0] = 1'b1; ad[0] = 32'd1024; wd[0] = 32'hDEADBEEF;
    round();
    rd[0] = 1'b1; ad[0] = 32'd1024;
    round();
    chk("readback_deadbeef", p0_rdata, 32'hDEADBEEF);
    wr = 2'b11; ad[0] = 32'd1028; ad[1] = 32'd1032; wd[0] = 32'h1111_0028; wd[1] = 32'h2222_0032;
    round();
    round();
    rd[0] = 1'b1; ad[0] = 32'd1028;
    wr[1] = 1'b1; ad[1] = 32'(BASE + 4 * 131071); wd[1] = 32'hCAFE_F00D;
    round();
    round();
    wr[0] = 1'b1; ad[0] = 32'd1036; wd[0] = 32'h0BAD_CAFE;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    last_g = 1'b1;
    #1;
    chk("mid_rst_we_n", SRAM_WE_N, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_grant", grant_id, 0);
    probe = 1'b1;
    #1 chk("mid_rst_dq_release", SRAM_DQ, 32'h0);
    probe = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    round();
    rd[0] = 1'b1; ad[0] = 32'd1036;
    round();
    repeat (80) begin
      for (int p = 0; p < 2; p++) begin
        if (!(rd[p] | wr[p]) && $urandom_range(0, 3) != 0) begin
          int op = $urandom_range(0, 2);
          rd[p] = op != 1;
          wr[p] = op != 0;
          ad[p] = pick();
          wd[p] = $urandom;
        end
      end
      if ((rd | wr) != 2'b00) round();
      else @(negedge clk);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
